// File: rtl/alu_sub_serial_16b_if.sv
// Start/done handshake and result bus between the ALU sequencer and the
// digit-serial subtractor.
interface alu_sub_serial_16b_if #(
  parameter int WIDTH = 16
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             sign;
  logic             zero;
  logic             parity;
  logic             overflow;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, sign, zero, parity, overflow
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, sign, zero, parity, overflow
  );
endinterface

// File: rtl/alu_sub_serial_16b.sv
// Digit-serial subtractor: diff = a - b - bin, DIGIT bits per cycle, LSB digit
// first, with registered borrow/sign/zero/parity/overflow flags.
module alu_sub_serial_16b #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input logic                clk,
  input logic                rst_n,
  alu_sub_serial_16b_if.slave bus
);
  localparam int NUM_DIG = WIDTH / DIGIT;
  localparam int CW      = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
  localparam logic [CW-1:0] LAST_DIG = CW'(NUM_DIG - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic             busy_c;
  logic             done_c;
  logic             accept;
  logic             last;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             borrow;
  logic             a_msb;
  logic             b_msb;
  logic [CW-1:0]    cnt;

  logic [DIGIT:0]   dig_sum;
  logic [WIDTH-1:0] dig_ext;
  logic [WIDTH-1:0] res_next;
  logic             borrow_next;

  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             sign_q;
  logic             zero_q;
  logic             parity_q;
  logic             overflow_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy_c     = 1'b0;
    done_c     = 1'b0;
    accept     = 1'b0;
    last       = (cnt == LAST_DIG);
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy_c = 1'b1;
        if (last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done_c = 1'b1;
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // One digit of a + ~b + ~borrow; the carry out is the inverted borrow.
  always_comb begin
    dig_sum     = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, ~b_sh[DIGIT-1:0]}
                + {{DIGIT{1'b0}}, ~borrow};
    borrow_next = ~dig_sum[DIGIT];
    dig_ext     = WIDTH'(dig_sum[DIGIT-1:0]);
    res_next    = (res_sh >> DIGIT) | (dig_ext << (WIDTH - DIGIT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      borrow <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sh   <= bus.a;
      b_sh   <= bus.b;
      res_sh <= '0;
      borrow <= bus.bin;
      a_msb  <= bus.a[WIDTH-1];
      b_msb  <= bus.b[WIDTH-1];
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> DIGIT;
      b_sh   <= b_sh >> DIGIT;
      res_sh <= res_next;
      borrow <= borrow_next;
      cnt    <= cnt + 1'b1;
    end
  end

  // Visible results change only on the edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q     <= '0;
      bout_q     <= 1'b0;
      sign_q     <= 1'b0;
      zero_q     <= 1'b0;
      parity_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else if (state == RUN && last) begin
      diff_q     <= res_next;
      bout_q     <= borrow_next;
      sign_q     <= res_next[WIDTH-1];
      zero_q     <= (res_next == '0);
      parity_q   <= ~(^res_next);
      overflow_q <= (a_msb & ~b_msb & ~res_next[WIDTH-1])
                  | (~a_msb & b_msb & res_next[WIDTH-1]);
    end
  end

  assign bus.busy     = busy_c;
  assign bus.done     = done_c;
  assign bus.diff     = diff_q;
  assign bus.bout     = bout_q;
  assign bus.sign     = sign_q;
  assign bus.zero     = zero_q;
  assign bus.parity   = parity_q;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_alu_sub_serial_16b.sv
// Directed bench for the digit-serial subtractor: latency, flags, back-to-back
// throughput, operand isolation and mid-operation reset.
module tb_alu_sub_serial_16b;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  alu_sub_serial_16b_if #(.WIDTH(16)) bus ();

  alu_sub_serial_16b #(.WIDTH(16), .DIGIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one request and returns how many falling edges after the accepting
  // edge it took to see done (5 means a latency of 4 edges).
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v,
                       input logic tbin, input bit scramble, output int n);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = ta;
    bus.b     = tb_v;
    bus.bin   = tbin;
    @(posedge clk);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        bus.start = 1'b0;
        if (scramble) begin
          bus.a   = ~ta;
          bus.b   = 16'h0F0F;
          bus.bin = ~tbin;
        end
      end
      if (bus.done === 1'b1) break;
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = 16'h0;
    bus.b     = 16'h0;
    bus.bin   = 1'b0;
    #12;
    checks++;
    if ({bus.busy, bus.done, bus.bout, bus.sign, bus.zero, bus.parity, bus.overflow} !== 7'b0) begin
      failures++;
      $display("[TB] FAIL reset_flags: got %b expected 0000000",
               {bus.busy, bus.done, bus.bout, bus.sign, bus.zero, bus.parity, bus.overflow});
    end
    checks++;
    if (bus.diff !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL reset_diff: got %h expected 0000", bus.diff);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int n;
    do_op(16'h0005, 16'h0003, 1'b0, 1'b0, n);
    checks++;
    if (n !== 5) begin
      failures++;
      $display("[TB] FAIL basic_latency: got %0d expected 5", n);
    end
    checks++;
    if (bus.diff !== 16'h0002) begin
      failures++;
      $display("[TB] FAIL basic_diff: got %h expected 0002", bus.diff);
    end
    checks++;
    if ({bus.bout, bus.sign, bus.zero, bus.parity, bus.overflow} !== 5'b00000) begin
      failures++;
      $display("[TB] FAIL basic_flags: got %b expected 00000",
               {bus.bout, bus.sign, bus.zero, bus.parity, bus.overflow});
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.done, bus.busy, bus.diff} !== {2'b00, 16'h0002}) begin
      failures++;
      $display("[TB] FAIL basic_hold: got done=%b busy=%b diff=%h expected 0 0 0002",
               bus.done, bus.busy, bus.diff);
    end
  endtask

  task automatic test_borrow_ripple();
    int n;
    do_op(16'h0000, 16'h0001, 1'b0, 1'b0, n);
    checks++;
    if (n !== 5 || bus.diff !== 16'hFFFF) begin
      failures++;
      $display("[TB] FAIL ripple_diff: got n=%0d diff=%h expected 5 FFFF", n, bus.diff);
    end
    checks++;
    if ({bus.bout, bus.sign, bus.zero, bus.parity, bus.overflow} !== 5'b11010) begin
      failures++;
      $display("[TB] FAIL ripple_flags: got %b expected 11010",
               {bus.bout, bus.sign, bus.zero, bus.parity, bus.overflow});
    end
  endtask

  task automatic test_overflow();
    int n;
    do_op(16'h8000, 16'h0001, 1'b0, 1'b0, n);
    checks++;
    if (n !== 5 || bus.diff !== 16'h7FFF) begin
      failures++;
      $display("[TB] FAIL ovf_neg_diff: got n=%0d diff=%h expected 5 7FFF", n, bus.diff);
    end
    checks++;
    if ({bus.bout, bus.sign, bus.zero, bus.parity, bus.overflow} !== 5'b00001) begin
      failures++;
      $display("[TB] FAIL ovf_neg_flags: got %b expected 00001",
               {bus.bout, bus.sign, bus.zero, bus.parity, bus.overflow});
    end
    do_op(16'h7FFF, 16'hFFFF, 1'b0, 1'b0, n);
    checks++;
    if (n !== 5 || bus.diff !== 16'h8000) begin
      failures++;
      $display("[TB] FAIL ovf_pos_diff: got n=%0d diff=%h expected 5 8000", n, bus.diff);
    end
    checks++;
    if ({bus.bout, bus.sign, bus.zero, bus.parity, bus.overflow} !== 5'b11001) begin
      failures++;
      $display("[TB] FAIL ovf_pos_flags: got %b expected 11001",
               {bus.bout, bus.sign, bus.zero, bus.parity, bus.overflow});
    end
  endtask

  task automatic test_zero_capture();
    int n;
    do_op(16'h1234, 16'h1233, 1'b1, 1'b1, n);
    checks++;
    if (n !== 5 || bus.diff !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL zero_diff: got n=%0d diff=%h expected 5 0000", n, bus.diff);
    end
    checks++;
    if ({bus.bout, bus.sign, bus.zero, bus.parity, bus.overflow} !== 5'b00110) begin
      failures++;
      $display("[TB] FAIL zero_flags: got %b expected 00110",
               {bus.bout, bus.sign, bus.zero, bus.parity, bus.overflow});
    end
  endtask

  // start stays high throughout; operands are junk while busy and only valid
  // on the cycle in which a new request can actually be accepted.
  task automatic test_back_to_back();
    logic [15:0] op_a   [3];
    logic [15:0] op_b   [3];
    logic        op_bin [3];
    logic [15:0] exp_d  [3];
    int          idx;
    int          cyc;
    int          last_done;
    op_a[0] = 16'h00FF; op_b[0] = 16'h0001; op_bin[0] = 1'b0; exp_d[0] = 16'h00FE;
    op_a[1] = 16'h1000; op_b[1] = 16'h0001; op_bin[1] = 1'b1; exp_d[1] = 16'h0FFE;
    op_a[2] = 16'hABCD; op_b[2] = 16'h1111; op_bin[2] = 1'b0; exp_d[2] = 16'h9ABC;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = op_a[0];
    bus.b     = op_b[0];
    bus.bin   = op_bin[0];
    idx       = 0;
    last_done = 0;
    cyc       = 0;
    while (idx < 3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.done === 1'b1) begin
        checks++;
        if (bus.diff !== exp_d[idx]) begin
          failures++;
          $display("[TB] FAIL b2b_diff%0d: got %h expected %h", idx, bus.diff, exp_d[idx]);
        end
        checks++;
        if (cyc - last_done !== 5) begin
          failures++;
          $display("[TB] FAIL b2b_spacing%0d: got %0d expected 5", idx, cyc - last_done);
        end
        last_done = cyc;
        idx++;
        if (idx < 3) begin
          bus.a   = op_a[idx];
          bus.b   = op_b[idx];
          bus.bin = op_bin[idx];
        end else begin
          bus.start = 1'b0;
        end
      end else begin
        bus.a   = 16'($urandom);
        bus.b   = 16'($urandom);
        bus.bin = 1'($urandom);
      end
    end
    bus.start = 1'b0;
    checks++;
    if (idx !== 3) begin
      failures++;
      $display("[TB] FAIL b2b_count: got %0d results expected 3", idx);
    end
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL b2b_idle: got busy=%b done=%b expected 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int seen;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 16'h5555;
    bus.b     = 16'h1111;
    bus.bin   = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.bout, bus.sign, bus.zero, bus.parity, bus.overflow} !== 7'b0
        || bus.diff !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL midreset_clear: got flags=%b diff=%h expected 0000000 0000",
               {bus.busy, bus.done, bus.bout, bus.sign, bus.zero, bus.parity, bus.overflow},
               bus.diff);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("[TB] FAIL midreset_nodone: got %0d active cycles expected 0", seen);
    end
    do_op(16'h0010, 16'h0001, 1'b0, 1'b0, n);
    checks++;
    if (n !== 5 || bus.diff !== 16'h000F) begin
      failures++;
      $display("[TB] FAIL midreset_fresh_diff: got n=%0d diff=%h expected 5 000F", n, bus.diff);
    end
    checks++;
    if ({bus.bout, bus.sign, bus.zero, bus.parity, bus.overflow} !== 5'b00010) begin
      failures++;
      $display("[TB] FAIL midreset_fresh_flags: got %b expected 00010",
               {bus.bout, bus.sign, bus.zero, bus.parity, bus.overflow});
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_borrow_ripple();
    test_overflow();
    test_zero_capture();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_sub_serial_16b.md
Name: alu_sub_serial_16b

Overview:
- Digit-serial 16-bit subtractor with ALU flags: computes diff = A - B - Bin, processing DIGIT bits per clock, LSB digit first.
- Counterpart (subtract direction) to the 16-bit flagged ripple adder in the ALU datapath.
- Used where area matters more than latency; start/done handshake toward the ALU sequencer.

Parameters:
WIDTH  16  operand/result width; must be an integer multiple of DIGIT
DIGIT  4   bits processed per RUN cycle; NUM_DIG = WIDTH/DIGIT (default 4)

Ports:
clk       input   1      clock, rising-edge
rst_n     input   1      asynchronous active-low reset
start     input   1      request; sampled only when busy=0
a         input   WIDTH  minuend, captured on accepted start
b         input   WIDTH  subtrahend, captured on accepted start
bin       input   1      borrow-in, captured on accepted start
busy      output  1      1 while a subtraction is in progress
done      output  1      one-cycle pulse: results valid/updated
diff      output  WIDTH  registered result A - B - Bin (mod 2^WIDTH)
bout      output  1      borrow-out: 1 iff unsigned A < B + Bin
sign      output  1      diff[WIDTH-1]
zero      output  1      1 iff diff == 0
parity    output  1      even parity: 1 iff diff has an even number of ones
overflow  output  1      signed overflow: (a_msb & ~b_msb & ~d_msb) | (~a_msb & b_msb & d_msb)

Behaviour:
- Reset (async assert, rst_n low): FSM to IDLE, digit counter 0, internal operand/borrow regs 0. busy=0, done=0, diff=0, bout=0, sign=0, zero=0, parity=0, overflow=0. Reset asserted mid-operation aborts the operation with no done pulse.
- Flags are registered values, not derived from diff. zero stays 0 after reset until the first completion.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 -> capture a, b, bin; internal borrow = bin; counter = 0; go to RUN.
  - RUN: each cycle, subtract digit[counter] of A and B with the running borrow (A + ~B + ~borrow per digit; borrow = ~carry). Shift the digit result into the internal result register; increment counter. After digit NUM_DIG-1 completes, go to DONE.
  - DONE: done=1 for exactly this cycle. start=1 here is accepted exactly as in IDLE (back-to-back) -> RUN; otherwise -> IDLE.
- busy=1 in RUN only; start while busy=1 is ignored (operands not recaptured).
- Timing: start sampled at edge t0 -> RUN during cycles t0..t0+NUM_DIG-1 -> output regs load at edge t0+NUM_DIG -> done=1 in the following cycle. Latency is NUM_DIG edges (4 for defaults). Sustained throughput is one result per NUM_DIG+1 cycles.
- diff and all flags update only at the edge entering DONE. They hold until the next completion; partial results are never visible.
- overflow uses the captured a/b MSBs and the final diff MSB.
- a, b, bin may change freely after capture without affecting the operation in flight.

Test Plan:
- a=0x0005, b=0x0003, bin=0 -> after 4 edges done=1; diff=0x0002, bout=0, sign=0, zero=0, parity=0, overflow=0.
- a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, sign=1, zero=0, parity=1, overflow=0 (borrow ripples through all digits).
- a=0x8000, b=0x0001, bin=0 -> diff=0x7FFF, bout=0, sign=0, parity=0, overflow=1. Then a=0x7FFF, b=0xFFFF -> diff=0x8000, bout=1, overflow=1.
- a=0x1234, b=0x1233, bin=1 -> diff=0x0000, zero=1, parity=1, bout=0. Change a/b on the cycle after start -> result unchanged.
- Start held high continuously with new operands each accept -> done pulses every 5 cycles. start pulsed while busy -> ignored; busy never re-triggers early.
- rst_n low during 2nd RUN cycle -> all outputs 0 immediately, no done pulse. After release, a fresh start completes correctly.
